// File: rtl/tt_sweep_pkg.sv
// Shared constants and types for the truth-table sweep collector.
package tt_sweep_pkg;

  localparam int unsigned NUM_IN_DEF = 7;
  localparam int unsigned TT_W_DEF   = 2 ** NUM_IN_DEF;
  localparam int unsigned WCNT_W     = 4;

  // Reference signature of the majority-network class under test.
  localparam logic [TT_W_DEF-1:0] EXPECTED_TT_DEF =
    128'hfeeaeac8eca8a888eeeaeac8eca8a880;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/tt_settle_counter.sv
// Settle-window counter (wcnt) and pattern index (idx) for the sweep.
// tick: this edge samples the current pattern. last: current pattern is the final one.
module tt_settle_counter
  import tt_sweep_pkg::*;
#(
  parameter int unsigned NUM_IN     = NUM_IN_DEF,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              en_i,
  output logic              tick_c_o,
  output logic              last_c_o,
  output logic [NUM_IN-1:0] idx_o
);

  localparam logic [NUM_IN-1:0] IDX_LAST = {NUM_IN{1'b1}};

  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [NUM_IN-1:0] idx_q, idx_d;

  assign tick_c_o = (wcnt_q == WCNT_W'(SETTLE_CYC));
  assign last_c_o = (idx_q == IDX_LAST);
  assign idx_o    = idx_q;

  // Next-state: wait out the settle window, then advance to the next pattern.
  always_comb begin
    wcnt_d = wcnt_q;
    idx_d  = idx_q;
    if (clear_i) begin
      wcnt_d = '0;
      idx_d  = '0;
    end else if (en_i) begin
      if (tick_c_o) begin
        wcnt_d = '0;
        if (!last_c_o) idx_d = idx_q + NUM_IN'(1);
      end else begin
        wcnt_d = wcnt_q + WCNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      idx_q  <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/tt_sweep_collector.sv
// Sweeps all input patterns onto a FUT, assembles its truth table and
// offers it on a valid/ready interface. Optional signature compare is
// enabled by defining SIGNATURE_CHECK_EN.
module tt_sweep_collector
  import tt_sweep_pkg::*;
#(
  parameter int unsigned                 NUM_IN      = NUM_IN_DEF,
  parameter int unsigned                 SETTLE_CYC  = 1,
  parameter logic [(2**NUM_IN)-1:0]      EXPECTED_TT = EXPECTED_TT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic [NUM_IN-1:0]        x,
  input  logic                     f_in,
  output logic                     tt_valid,
  input  logic                     tt_ready,
  output logic [(2**NUM_IN)-1:0]   tt_data,
  output logic [15:0]              sweep_cnt,
  output logic                     match
);

  localparam int unsigned TT_W = 2 ** NUM_IN;

  state_e            state_q;
  logic              busy_q;
  logic              valid_q;
  logic [NUM_IN-1:0] x_q;
  logic [TT_W-1:0]   cap_q;
  logic [15:0]       cnt_q;

  logic              tick_c;
  logic              last_c;
  logic [NUM_IN-1:0] idx_c;

  tt_settle_counter #(
    .NUM_IN     (NUM_IN),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  ((state_q == IDLE) && start),
    .en_i     (state_q == SWEEP),
    .tick_c_o (tick_c),
    .last_c_o (last_c),
    .idx_o    (idx_c)
  );

  assign busy      = busy_q;
  assign x         = x_q;
  assign tt_valid  = valid_q;
  assign tt_data   = cap_q;
  assign sweep_cnt = cnt_q;

  // Sweep control: accept start, capture samples, hold result until handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      x_q     <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SWEEP;
            busy_q  <= 1'b1;
            x_q     <= '0;
            cap_q   <= '0;
          end
        end
        SWEEP: begin
          if (tick_c) begin
            cap_q[idx_c] <= f_in;
            if (last_c) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
            end else begin
              x_q <= idx_c + NUM_IN'(1);
            end
          end
        end
        HOLD: begin
          if (tt_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SIGNATURE_CHECK_EN
  logic            match_q;
  logic [TT_W-1:0] cap_final_c;

  // Capture value including the sample taken on the HOLD-entry edge.
  always_comb begin
    cap_final_c        = cap_q;
    cap_final_c[idx_c] = f_in;
  end

  // Signature flag: latched on HOLD entry, cleared on leaving HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
    end else if ((state_q == SWEEP) && tick_c && last_c) begin
      match_q <= (cap_final_c == EXPECTED_TT);
    end else if ((state_q == HOLD) && tt_ready) begin
      match_q <= 1'b0;
    end
  end

  assign match = match_q;
`else
  logic unused_expected;
  assign unused_expected = ^EXPECTED_TT;
  assign match           = 1'b0;
`endif

endmodule
